// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot select decoder with range checking and an
// optional self-scanning mode for display/LED-matrix multiplexing.
module decoder_scan #(
  parameter int unsigned W          = 2,
  parameter int unsigned N          = 4,
  parameter int unsigned DIV        = 4,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [W-1:0]        code,
  input  logic                blank,
  output logic [(2**W)-1:0]   onehot,
  output logic [W-1:0]        index,
  output logic                wrap,
  output logic                oor
);

  localparam int unsigned OW = 2 ** W;
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [OW-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OW{1'b1}} : {OW{1'b0}};

  logic [W-1:0]  index_q, index_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          wrap_q, wrap_d;
  logic          oor_q, oor_d;
  logic [OW-1:0] onehot_q, onehot_d;
  logic [OW-1:0] raw_d;

  // Next index, prescaler, wrap and range flag.
  always_comb begin
    index_d = index_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;
    oor_d   = oor_q;
    if (!mode) begin
      if (en) begin
        index_d = code;
        oor_d   = ({1'b0, code} >= (W+1)'(N));
        pre_d   = '0;
      end
    end else begin
      oor_d = 1'b0;
      if (en) begin
        if (pre_q == PW'(DIV - 1)) begin
          pre_d = '0;
          if ({1'b0, index_q} < (W+1)'(N - 1)) begin
            index_d = index_q + W'(1);
          end else begin
            index_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
    end
  end

  // Decode from next-state values so onehot lines up with index; outputs
  // at or above N are unused and never driven active.
  always_comb begin
    raw_d = '0;
    for (int unsigned i = 0; i < OW; i++) begin
      raw_d[i] = (index_d == W'(i)) && (i < N) && !oor_d && !blank;
    end
    onehot_d = raw_d ^ INACTIVE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q  <= '0;
      pre_q    <= '0;
      wrap_q   <= 1'b0;
      oor_q    <= 1'b0;
      onehot_q <= INACTIVE;
    end else begin
      index_q  <= index_d;
      pre_q    <= pre_d;
      wrap_q   <= wrap_d;
      oor_q    <= oor_d;
      onehot_q <= onehot_d;
    end
  end

  assign onehot = onehot_q;
  assign index  = index_q;
  assign wrap   = wrap_q;
  assign oor    = oor_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: four parameterisations share one stimulus.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic [2:0] code;
  logic       blank;

  logic [3:0] oh_a, oh_c, oh_d;
  logic [7:0] oh_b;
  logic [1:0] idx_a, idx_c, idx_d;
  logic [2:0] idx_b;
  logic       wr_a, wr_b, wr_c, wr_d;
  logic       oor_a, oor_b, oor_c, oor_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // A: W=2 N=4 DIV=1
  decoder_scan #(.W(2), .N(4), .DIV(1), .ACTIVE_LOW(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .code(code[1:0]), .blank(blank),
    .onehot(oh_a), .index(idx_a), .wrap(wr_a), .oor(oor_a));
  // B: W=3 N=5 DIV=4
  decoder_scan #(.W(3), .N(5), .DIV(4), .ACTIVE_LOW(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .code(code), .blank(blank),
    .onehot(oh_b), .index(idx_b), .wrap(wr_b), .oor(oor_b));
  // C: W=2 N=3 DIV=4
  decoder_scan #(.W(2), .N(3), .DIV(4), .ACTIVE_LOW(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .code(code[1:0]), .blank(blank),
    .onehot(oh_c), .index(idx_c), .wrap(wr_c), .oor(oor_c));
  // D: W=2 N=3 DIV=2 active-low
  decoder_scan #(.W(2), .N(3), .DIV(2), .ACTIVE_LOW(1)) u_d (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .code(code[1:0]), .blank(blank),
    .onehot(oh_d), .index(idx_d), .wrap(wr_d), .oor(oor_d));

  typedef struct {
    logic       en;
    logic       mode;
    logic [2:0] code;
    logic       blank;
    int         sel;
    logic [7:0] oh;
    logic [2:0] idx;
    logic       wrap;
    logic       oor;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic sample(input int sel, output logic [7:0] oh, output logic [2:0] idx,
                        output logic wr, output logic o);
    case (sel)
      0: begin oh = {4'b0, oh_a}; idx = {1'b0, idx_a}; wr = wr_a; o = oor_a; end
      1: begin oh = oh_b;         idx = idx_b;         wr = wr_b; o = oor_b; end
      2: begin oh = {4'b0, oh_c}; idx = {1'b0, idx_c}; wr = wr_c; o = oor_c; end
      default: begin oh = {4'b0, oh_d}; idx = {1'b0, idx_d}; wr = wr_d; o = oor_d; end
    endcase
  endtask

  task automatic check_all(input string name, input int sel, input logic [7:0] eoh,
                           input logic [2:0] eidx, input logic ewr, input logic eoor);
    logic [7:0] oh;
    logic [2:0] idx;
    logic       wr, o;
    sample(sel, oh, idx, wr, o);
    chk({name, ".onehot"}, oh, eoh);
    chk({name, ".index"}, {5'b0, idx}, {5'b0, eidx});
    chk({name, ".wrap"}, {7'b0, wr}, {7'b0, ewr});
    chk({name, ".oor"}, {7'b0, o}, {7'b0, eoor});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle asynchronous reset pulse; leaves rst high for the caller to release.
  task automatic async_reset();
    rst = 1'b1;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timeout reached, expected finish");
    $fatal(1);
  end

  vec_t vt [$];

  initial begin
    logic [3:0] e4;
    logic [1:0] ei;

    // Directed vectors applied one clock each after a clean reset.
    vt.push_back('{1'b1, 1'b0, 3'd2, 1'b0, 0, 8'h04, 3'd2, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 3'd3, 1'b0, 0, 8'h08, 3'd3, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 3'd1, 1'b0, 0, 8'h08, 3'd3, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 3'd6, 1'b0, 1, 8'h00, 3'd6, 1'b0, 1'b1});
    vt.push_back('{1'b1, 1'b0, 3'd4, 1'b0, 1, 8'h10, 3'd4, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 3'd7, 1'b1, 1, 8'h00, 3'd7, 1'b0, 1'b1});
    vt.push_back('{1'b1, 1'b0, 3'd1, 1'b1, 1, 8'h00, 3'd1, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 3'd1, 1'b0, 1, 8'h02, 3'd1, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 3'd5, 1'b0, 1, 8'h00, 3'd5, 1'b0, 1'b1});
    vt.push_back('{1'b1, 1'b1, 3'd0, 1'b0, 0, 8'h04, 3'd2, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 3'd0, 1'b0, 0, 8'h08, 3'd3, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 3'd0, 1'b0, 0, 8'h01, 3'd0, 1'b1, 1'b0});
    vt.push_back('{1'b0, 1'b1, 3'd0, 1'b0, 0, 8'h01, 3'd0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 3'd2, 1'b0, 0, 8'h01, 3'd0, 1'b0, 1'b0});

    rst = 1'b1; en = 1'b0; mode = 1'b0; code = '0; blank = 1'b0;
    #12;
    check_all("reset_a", 0, 8'h00, 3'd0, 1'b0, 1'b0);
    check_all("reset_d", 3, 8'h0f, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    foreach (vt[i]) begin
      en = vt[i].en; mode = vt[i].mode; code = vt[i].code; blank = vt[i].blank;
      step();
      check_all($sformatf("vec%0d", i), vt[i].sel, vt[i].oh, vt[i].idx, vt[i].wrap, vt[i].oor);
    end

    // Async reset mid-cycle from a non-zero state.
    en = 1'b1; mode = 1'b0; code = 3'd2;
    step();
    check_all("pre_rst_a", 0, 8'h04, 3'd2, 1'b0, 1'b0);
    async_reset();
    check_all("async_rst_a", 0, 8'h00, 3'd0, 1'b0, 1'b0);
    check_all("async_rst_d", 3, 8'h0f, 3'd0, 1'b0, 1'b0);
    mode = 1'b1; en = 1'b1; blank = 1'b0;
    #2 rst = 1'b0;

    // Scan N=3 DIV=4: index changes every 4 edges, wrap on edge 12.
    for (int k = 1; k <= 14; k++) begin
      step();
      ei = 2'((k / 4) % 3);
      e4 = 4'b0001 << ei;
      check_all($sformatf("scan_c%0d", k), 2, {4'b0, e4}, {1'b0, ei}, (k == 12), 1'b0);
    end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_all($sformatf("freeze_c%0d", k), 2, 8'h01, 3'd0, 1'b0, 1'b0);
    end
    en = 1'b1;
    step();
    check_all("resume_c0", 2, 8'h01, 3'd0, 1'b0, 1'b0);
    step();
    check_all("resume_c1", 2, 8'h02, 3'd1, 1'b0, 1'b0);

    // Active-low scan with blank, N=3 DIV=2.
    async_reset();
    check_all("rst_d", 3, 8'h0f, 3'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      blank = (k == 5 || k == 6);
      step();
      ei = 2'((k / 2) % 3);
      e4 = blank ? 4'b1111 : ~(4'b0001 << ei);
      check_all($sformatf("al_d%0d", k), 3, {4'b0, e4}, {1'b0, ei}, (k == 6), 1'b0);
    end
    blank = 1'b0;

    // Out-of-range direct code, then switch to scan: oor clears, wrap after DIV edges.
    mode = 1'b0; en = 1'b1; code = 3'd3;
    step();
    check_all("oor_c", 2, 8'h00, 3'd3, 1'b0, 1'b1);
    mode = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_all($sformatf("sw_c%0d", k), 2, 8'h00, 3'd3, 1'b0, 1'b0);
    end
    step();
    check_all("sw_wrap_c", 2, 8'h01, 3'd0, 1'b1, 1'b0);

    // Reset during scan at index 2, prescaler 2.
    for (int k = 0; k < 10; k++) step();
    check_all("pre_rst_c", 2, 8'h04, 3'd2, 1'b0, 1'b0);
    async_reset();
    check_all("scan_rst_c", 2, 8'h00, 3'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      ei = (k == 4) ? 2'd1 : 2'd0;
      e4 = 4'b0001 << ei;
      check_all($sformatf("post_rst_c%0d", k), 2, {4'b0, e4}, {1'b0, ei}, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised registered binary-to-one-hot decoder for digit/row select lines (7-seg digit enables, LED-matrix rows).
- Direct mode: decodes an external code, as the combinational 2-to-4 decoder did, but registered, wider and with range checking.
- Scan mode: an internal prescaled counter walks the active output, so display multiplexing needs no external counter.

Parameters:
- W, 2, code/index width; output width is 2**W.
- N, 4, number of used outputs (1 <= N <= 2**W); scan cycles 0..N-1; codes >= N are out of range.
- DIV, 4, scan prescaler: the index advances once every DIV enabled cycles (DIV >= 1).
- ACTIVE_LOW, 0, 1 = inverts every bit of onehot (common-anode drive).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  enable: direct mode loads code; scan mode runs the prescaler
- mode  in  1  0 = direct decode, 1 = scan
- code  in  W  binary code for direct mode
- blank  in  1  forces all outputs inactive; counters unaffected
- onehot  out  2**W  registered one-hot select (polarity per ACTIVE_LOW)
- index  out  W  registered current index
- wrap  out  1  one-cycle pulse when scan index wraps N-1 -> 0
- oor  out  1  registered; 1 while the last loaded direct code was >= N

Behaviour:
- Reset (asynchronous, immediate, also mid-scan):
  - index = 0, prescaler = 0, wrap = 0, oor = 0.
  - onehot all inactive: 0s, or all 1s when ACTIVE_LOW = 1.
- Internal raw_onehot[i] = (i == index) && !oor && !blank_q.
  - blank_q is blank registered, so blank has 1-cycle latency like everything else.
  - onehot = raw_onehot XOR {2**W{ACTIVE_LOW}}.
- All outputs are registered; no combinational path from inputs to outputs.
- Direct mode (mode = 0):
  - Edge with en = 1: index <= code; oor <= (code >= N); prescaler <= 0. onehot reflects the new code 1 cycle after the sampling edge.
  - en = 0: index and oor hold.
  - wrap is always 0 in direct mode.
  - Code >= N: index still loads code, oor = 1, all outputs inactive.
- Scan mode (mode = 1):
  - oor is cleared on the first scan-mode edge.
  - en = 1: prescaler counts 0..DIV-1. On the edge where prescaler == DIV-1, prescaler <= 0 and index advances.
  - Advance rule: index <= index+1 if index < N-1, else 0. On the wrap edge, wrap <= 1 for exactly one cycle.
  - DIV = 1: index advances on every enabled edge.
  - en = 0: prescaler and index freeze; wrap <= 0.
  - If index >= N on entry (left over from direct mode), the next advance goes to 0 and pulses wrap.
- Mode switch:
  - Direct -> scan: scanning starts from the current index with the prescaler as left. Direct-mode loads zero it; otherwise it is the value left when scan was last exited.
  - Scan -> direct: index holds until an en = 1 load.
- blank only masks onehot; index, prescaler, wrap and oor run normally.
- Arithmetic:
  - Prescaler width is clog2(DIV), minimum 1 bit.
  - The code >= N compare is unsigned at W+1 bits, so N = 2**W never flags.

Test Plan:
1. Reset, W=2, N=4, DIV=1: assert rst mid-cycle -> onehot = 0000 and index = 0 immediately. Release, mode=0, en=1, code=2 -> onehot = 0100 one edge later; code=3 -> 1000.
2. Direct out of range, W=3, N=5: code=6, en=1 -> index = 6, oor = 1, onehot = 00000000. Then code=4 -> oor = 0, onehot = 00010000.
3. Scan, W=2, N=3, DIV=4, en=1:
   - index sequence 0, 1, 2, 0, changing every 4 cycles; onehot 0001, 0010, 0100.
   - wrap high for exactly 1 cycle on the 2 -> 0 transition (cycle 12 after start).
   - Drop en for 5 cycles -> index and prescaler frozen, no wrap.
4. ACTIVE_LOW = 1 with blank: scan running -> onehot = 1110, 1101, ...; blank = 1 -> 1111 one cycle later while index keeps advancing; release -> active bit matches current index.
5. Mode switch, N=3: direct code=3 (oor = 1) then mode=1 -> oor clears on that first scan edge, onehot stays all-inactive while index = 3; after DIV enabled cycles index = 0 with a wrap pulse.
6. Reset during scan: rst asserted at index 2 with prescaler = 2 -> after release, the next advance happens exactly DIV enabled cycles later, from index 0.
